// File: rtl/avalon_pkg.sv
// Shared types and width helpers for the Avalon-ST packet utilities.
package avalon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IN_PKT = 2'd1,
      DROP   = 2'd2
   } meter_state_e;

   // Bits needed to hold a byte count from 0 up to max_beats*bytes_per_beat.
   function automatic int len_width(input int max_beats, input int bytes_per_beat);
      return $clog2(max_beats * bytes_per_beat + 1);
   endfunction

   function automatic int empty_width(input int bytes_per_beat);
      return (bytes_per_beat > 1) ? $clog2(bytes_per_beat) : 1;
   endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST framed stream bundle: data with sop/eop/empty and valid/rdy handshake.
interface avalon_st_if
   import avalon_pkg::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16
);
   localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

   logic                               valid;
   logic                               rdy;
   logic [8*DATA_WIDTH_IN_BYTES-1:0]   data;
   logic                               sop;
   logic                               eop;
   logic [EMPTY_W-1:0]                 empty;

   modport master (output valid, data, sop, eop, empty, input rdy);
   modport slave  (input valid, data, sop, eop, empty, output rdy);

endinterface

// File: rtl/avalon_pkt_len_meter.sv
// Forwards framed packets with one register stage, truncating any packet longer
// than MAX_PKT_BEATS beats and reporting the byte length of each packet sent.
module avalon_pkt_len_meter
   import avalon_pkg::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16,
   parameter int MAX_PKT_BEATS       = 64,
   localparam int LEN_W = len_width(MAX_PKT_BEATS, DATA_WIDTH_IN_BYTES)
) (
   input  logic             clk,
   input  logic             rst,
   avalon_st_if.slave       in_msg,
   avalon_st_if.master      out_msg,
   output logic [LEN_W-1:0] pkt_len,
   output logic             pkt_len_valid,
   output logic             pkt_too_long
);

   localparam int DW      = 8 * DATA_WIDTH_IN_BYTES;
   localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
   localparam int BEAT_W  = $clog2(MAX_PKT_BEATS + 1);

   meter_state_e       state_q, state_d;
   logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;

   logic               out_valid_q;
   logic [DW-1:0]      out_data_q;
   logic               out_sop_q;
   logic               out_eop_q;
   logic [EMPTY_W-1:0] out_empty_q;

   logic [LEN_W-1:0]   pkt_len_q;
   logic               pkt_len_valid_q;
   logic               pkt_too_long_q;

   logic               in_rdy;
   logic               in_fire;
   logic [LEN_W-1:0]   beat_bytes;
   logic [BEAT_W-1:0]  new_beats;
   logic [LEN_W-1:0]   new_bytes;
   logic               at_limit;
   logic               fwd;
   logic               fwd_sop;
   logic               fwd_eop;
   logic [EMPTY_W-1:0] fwd_empty;
   logic               len_done;
   logic               len_trunc;

   always_comb begin
      in_rdy     = (state_q == DROP) || !out_valid_q || out_msg.rdy;
      in_fire    = in_msg.valid && in_rdy;
      beat_bytes = in_msg.eop ? (LEN_W'(DATA_WIDTH_IN_BYTES) - LEN_W'(in_msg.empty))
                              : LEN_W'(DATA_WIDTH_IN_BYTES);
      // A sop taken in IDLE restarts both counts from zero.
      new_beats  = (state_q == IDLE) ? BEAT_W'(1) : beat_cnt_q + BEAT_W'(1);
      new_bytes  = ((state_q == IDLE) ? '0 : byte_cnt_q) + beat_bytes;
      at_limit   = !in_msg.eop && (new_beats == BEAT_W'(MAX_PKT_BEATS));

      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      byte_cnt_d = byte_cnt_q;
      fwd        = 1'b0;
      fwd_sop    = 1'b0;
      fwd_eop    = in_msg.eop;
      fwd_empty  = in_msg.empty;
      len_done   = 1'b0;
      len_trunc  = 1'b0;

      if (in_fire) begin
         case (state_q)
            IDLE, IN_PKT: begin
               if ((state_q == IN_PKT) || in_msg.sop) begin
                  fwd        = 1'b1;
                  fwd_sop    = (state_q == IDLE);
                  beat_cnt_d = new_beats;
                  byte_cnt_d = new_bytes;
                  if (in_msg.eop) begin
                     len_done = 1'b1;
                     state_d  = IDLE;
                  end else if (at_limit) begin
                     // Close the packet early; the remainder is swallowed in DROP.
                     fwd_eop   = 1'b1;
                     fwd_empty = '0;
                     len_done  = 1'b1;
                     len_trunc = 1'b1;
                     state_d   = DROP;
                  end else begin
                     state_d = IN_PKT;
                  end
               end
            end
            DROP: begin
               if (in_msg.eop) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         beat_cnt_q      <= '0;
         byte_cnt_q      <= '0;
         out_valid_q     <= 1'b0;
         pkt_len_q       <= '0;
         pkt_len_valid_q <= 1'b0;
         pkt_too_long_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         beat_cnt_q      <= beat_cnt_d;
         byte_cnt_q      <= byte_cnt_d;
         pkt_len_valid_q <= len_done;
         pkt_too_long_q  <= len_trunc;
         if (len_done) pkt_len_q <= new_bytes;
         if (fwd) out_valid_q <= 1'b1;
         else if (out_msg.rdy) out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (fwd) begin
         out_data_q  <= in_msg.data;
         out_sop_q   <= fwd_sop;
         out_eop_q   <= fwd_eop;
         out_empty_q <= fwd_empty;
      end
   end

   assign in_msg.rdy     = in_rdy;
   assign out_msg.valid  = out_valid_q;
   assign out_msg.data   = out_data_q;
   assign out_msg.sop    = out_sop_q;
   assign out_msg.eop    = out_eop_q;
   assign out_msg.empty  = out_empty_q;
   assign pkt_len        = pkt_len_q;
   assign pkt_len_valid  = pkt_len_valid_q;
   assign pkt_too_long   = pkt_too_long_q;

endmodule

// File: tb/tb_avalon_pkt_len_meter.sv
// Directed and randomized checks of avalon_pkt_len_meter against a per-packet reference model.
module tb_avalon_pkt_len_meter;
   import avalon_pkg::*;

   localparam int W     = 16;
   localparam int MAXB  = 4;
   localparam int LEN_W = len_width(MAXB, W);
   localparam int DW    = 8 * W;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic [3:0]    empty;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) in_if ();
   avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) out_if ();
   logic [LEN_W-1:0] pkt_len;
   logic             pkt_len_valid;
   logic             pkt_too_long;

   avalon_pkt_len_meter #(.DATA_WIDTH_IN_BYTES(W), .MAX_PKT_BEATS(MAXB)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_msg        (in_if),
      .out_msg       (out_if),
      .pkt_len       (pkt_len),
      .pkt_len_valid (pkt_len_valid),
      .pkt_too_long  (pkt_too_long)
   );

   int               tests = 0;
   int               fails = 0;
   beat_t            exp_q[$];
   logic [LEN_W:0]   len_q[$];
   logic [LEN_W-1:0] last_len = '0;
   bit               bp_en = 0, lat_chk = 0, stall_chk = 0;
   int               stall_left = 0;
   bit               cur_fwd = 0, pend_fwd = 0, fired = 0, held = 0;
   beat_t            held_beat;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive out rdy, observe everything at negedge, step past posedge.
   task automatic tick();
      beat_t          ob;
      beat_t          eb;
      logic [LEN_W:0] el;
      if (stall_left > 0) begin
         out_if.rdy = 1'b0;
         stall_left--;
      end else begin
         out_if.rdy = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      @(negedge clk);
      ob = {out_if.data, out_if.sop, out_if.eop, out_if.empty};
      if (held) begin
         check("hold_valid", 192'(out_if.valid), 192'(1'b1));
         check("hold_stable", 192'(ob), 192'(held_beat));
      end
      if (lat_chk) check("out_latency", 192'(out_if.valid), 192'(pend_fwd));
      if (stall_chk && !out_if.rdy && out_if.valid) check("stall_in_rdy", 192'(in_if.rdy), 192'(1'b0));
      if (out_if.valid && out_if.rdy) begin
         check("out_beat_pending", 192'(exp_q.size() > 0), 192'(1'b1));
         if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            check("out_beat", 192'(ob), 192'(eb));
         end
      end
      if (pkt_len_valid) begin
         check("len_pending", 192'(len_q.size() > 0), 192'(1'b1));
         if (len_q.size() > 0) begin
            el = len_q.pop_front();
            check("pkt_len", 192'({pkt_too_long, pkt_len}), 192'(el));
            last_len = el[LEN_W-1:0];
         end
      end else begin
         check("len_hold", 192'({pkt_too_long, pkt_len}), 192'({1'b0, last_len}));
      end
      held      = out_if.valid && !out_if.rdy;
      held_beat = ob;
      fired     = in_if.valid && in_if.rdy;
      pend_fwd  = fired && cur_fwd;
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input beat_t b, input bit fwd);
      in_if.data  = b.data;
      in_if.sop   = b.sop;
      in_if.eop   = b.eop;
      in_if.empty = b.empty;
      in_if.valid = 1'b1;
      cur_fwd     = fwd;
      fired       = 1'b0;
      for (int t = 0; t < 200 && !fired; t++) tick();
      check("beat_accepted", 192'(fired), 192'(1'b1));
      cur_fwd = 1'b0;
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference: first MAXB beats pass (sop only on beat 1); a packet longer than
   // MAXB ends at beat MAXB with eop=1, empty=0 and reports MAXB*W bytes.
   task automatic send_pkt(input int n, input logic [3:0] last_empty, input bit mid_sop, input int stall_n);
      beat_t b;
      beat_t e;
      bit    trunc;
      int    nbytes;
      trunc  = (n > MAXB);
      nbytes = trunc ? MAXB * W : n * W - int'(last_empty);
      len_q.push_back({trunc, LEN_W'(nbytes)});
      for (int i = 1; i <= n; i++) begin
         b.data  = rand_data();
         b.sop   = (i == 1) ? 1'b1 : (mid_sop ? 1'($urandom_range(0, 1)) : 1'b0);
         b.eop   = (i == n);
         b.empty = (i == n) ? last_empty : 4'($urandom_range(0, 15));
         if (i <= MAXB) begin
            e     = b;
            e.sop = (i == 1);
            if (i == MAXB && i != n) begin
               e.eop   = 1'b1;
               e.empty = 4'd0;
            end
            exp_q.push_back(e);
         end
         if (i == 2) stall_left = stall_n;
         send_beat(b, i <= MAXB);
      end
      in_if.valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && (exp_q.size() > 0 || len_q.size() > 0); t++) tick();
      repeat (3) tick();
      check("drain_beats", 192'(exp_q.size()), 192'(0));
      check("drain_lens", 192'(len_q.size()), 192'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      beat_t b;
      in_if.valid = 1'b0;
      in_if.data  = '0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
      in_if.empty = '0;
      out_if.rdy  = 1'b1;
      rst         = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 192'(out_if.valid), 192'(1'b0));
      check("rst_pkt_len", 192'(pkt_len), 192'(0));
      check("rst_len_valid", 192'(pkt_len_valid), 192'(1'b0));
      check("rst_too_long", 192'(pkt_too_long), 192'(1'b0));
      check("rst_in_rdy", 192'(in_if.rdy), 192'(1'b1));
      @(posedge clk);
      #1;

      // Directed, out rdy held high, one-cycle latency checked.
      lat_chk = 1;
      send_pkt(3, 4'd5, 0, 0);
      send_pkt(1, 4'd15, 0, 0);
      send_pkt(6, 4'd7, 0, 0);
      send_pkt(4, 4'd3, 0, 0);
      b = '{data: rand_data(), sop: 1'b0, eop: 1'b1, empty: 4'd2};
      send_beat(b, 0);
      in_if.valid = 1'b0;
      drain();

      // Three-cycle output stall starting while beat 1 is on out_msg.
      lat_chk   = 0;
      stall_chk = 1;
      send_pkt(3, 4'd2, 0, 3);
      drain();
      stall_chk = 0;

      // Reset after beat 2 of a long packet: two beats out, no length pulse.
      for (int i = 1; i <= 2; i++) begin
         b = '{data: rand_data(), sop: (i == 1), eop: 1'b0, empty: 4'd0};
         exp_q.push_back(b);
         send_beat(b, 1);
      end
      in_if.valid = 1'b0;
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      last_len = '0;
      held     = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 192'(out_if.valid), 192'(1'b0));
      check("midrst_len_valid", 192'(pkt_len_valid), 192'(1'b0));
      check("midrst_pkt_len", 192'(pkt_len), 192'(0));
      @(posedge clk);
      #1;
      send_pkt(2, 4'd0, 0, 0);
      drain();

      // Randomized traffic with backpressure, stray sop=0 beats and mid-packet sop.
      bp_en = 1;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = '{data: rand_data(), sop: 1'b0, eop: 1'($urandom_range(0, 1)), empty: 4'($urandom_range(0, 15))};
            send_beat(b, 0);
            in_if.valid = 1'b0;
         end
         send_pkt($urandom_range(1, 7), 4'($urandom_range(0, 15)), 1, 0);
         if ($urandom_range(0, 1) == 1) tick();
      end
      bp_en = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/avalon_pkt_len_meter.md
AVALON_PKT_LEN_METER -- requirements
Module: avalon_pkt_len_meter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_IN_BYTES, default 16, giving the stream data width in bytes.
REQ-002 The block SHALL have parameter MAX_PKT_BEATS, default 64, giving the maximum beats forwarded per packet.
REQ-003 The block SHALL have derived constant LEN_W = $clog2(MAX_PKT_BEATS*DATA_WIDTH_IN_BYTES+1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_msg, avalon_st_if.slave, DATA_WIDTH_IN_BYTES, the framed stream from the avalon_enforcer trusted output.
REQ-007 The block SHALL have port out_msg, avalon_st_if.master, DATA_WIDTH_IN_BYTES, the length-limited stream.
REQ-008 The block SHALL have port pkt_len, output, LEN_W, the byte count of the last completed packet.
REQ-009 The block SHALL have port pkt_len_valid, output, 1, a one-cycle pulse qualifying pkt_len.
REQ-010 The block SHALL have port pkt_too_long, output, 1, a one-cycle pulse flagging that the last packet was truncated.

Function
REQ-011 A beat SHALL transfer on either interface only when valid and rdy are both 1 on a clock edge.
REQ-012 in_msg.rdy SHALL equal (!out_msg.valid || out_msg.rdy) in IDLE/IN_PKT, and 1 in DROP.
REQ-013 Accepted forwarded beats SHALL appear on out_msg with one cycle latency; data, sop, eop and empty SHALL stay unchanged while out_msg.valid=1 and out_msg.rdy=0.
REQ-014 The FSM SHALL have states IDLE, IN_PKT and DROP; the reset state is IDLE.
REQ-015 IDLE: a beat with sop=1 SHALL be forwarded and start the count; the next state is IN_PKT, or IDLE if eop=1 on the same beat; a beat with sop=0 SHALL be discarded.
REQ-016 IN_PKT: beats SHALL be forwarded with sop forced to 0; an accepted eop returns the FSM to IDLE.
REQ-017 Beat bytes SHALL be DATA_WIDTH_IN_BYTES on non-eop beats and DATA_WIDTH_IN_BYTES-empty on eop beats; the count is LEN_W bits and cannot overflow given REQ-018.
REQ-018 Truncation: a non-eop beat accepted as beat number MAX_PKT_BEATS SHALL be forwarded with eop=1 and empty=0; the FSM SHALL go to DROP.
REQ-019 A packet whose eop arrives exactly on beat MAX_PKT_BEATS SHALL be forwarded normally, with no truncation.
REQ-020 DROP: all beats SHALL be accepted and discarded, nothing forwarded; an accepted eop returns the FSM to IDLE.
REQ-021 pkt_len and pkt_len_valid SHALL update in the cycle after the forwarded eop beat (real or forced) is accepted on in_msg, independent of out_msg stall; pkt_len holds between pulses.
REQ-022 pkt_too_long SHALL pulse coincident with pkt_len_valid for truncated packets; pkt_len is then MAX_PKT_BEATS*DATA_WIDTH_IN_BYTES.
REQ-023 Beat and byte counters SHALL clear on every sop accepted in IDLE.

Reset
REQ-024 On rst=1 the block SHALL set state=IDLE, out_msg.valid=0, counters=0, pkt_len=0, pkt_len_valid=0 and pkt_too_long=0 on the next edge.
REQ-025 Reset mid-packet SHALL abandon the packet with no length pulse; the first sop after reset starts a new count.

Structure
REQ-026 The FSM state enum and the length-width function SHALL reside in shared package avalon_pkg.
REQ-027 No sub-module is required; the output register and FSM SHALL be in one module.

Verification (DATA_WIDTH_IN_BYTES=16, MAX_PKT_BEATS=4, out_msg.rdy=1 unless stated)
REQ-028 3-beat packet, eop empty=5 -> identical beats on out_msg one cycle later; pkt_len=43; pkt_too_long=0.
REQ-029 Single beat sop=eop=1, empty=15 -> one output beat with sop=eop=1; pkt_len=1; FSM stays IDLE.
REQ-030 6-beat packet -> 4 output beats, beat 4 has eop=1, empty=0; beats 5-6 accepted (rdy=1) and discarded; pkt_len=64; pkt_too_long=1 for one cycle.
REQ-031 Exactly 4 beats, eop empty=3 -> all forwarded unchanged; pkt_len=61; pkt_too_long=0.
REQ-032 out_msg.rdy=0 for 3 cycles mid-packet -> in_msg.rdy=0 during the stall; out_msg beat held stable; no loss or duplication; pkt_len correct.
REQ-033 rst=1 after beat 2 of a packet -> out_msg.valid=0 next cycle; no pulse; next 2-beat packet gives pkt_len=32 with eop empty=0.
